// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one TX FIFO write port among NREQ byte streams; grants last a packet.
// Optional build macro UART_ARB_PRIO_EN: requester 0 gets absolute priority and is exempt from MAX_BURST.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DBIT      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      grant,
    input  logic                 tx_full,
    output logic                 wr,
    output logic [DBIT-1:0]      w_data,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]      r_state;
    logic [NREQ-1:0] r_grant;
    logic [PW-1:0]   r_g;
    logic [PW-1:0]   r_rr;
    logic [CW-1:0]   r_cnt;

    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_idx;
    logic            w_xfer;
    logic            w_accept;
    logic            w_exempt;
    logic            w_limit;
    logic            w_release;

    // Scan downward so the candidate closest to rr_ptr+1 is written last and wins.
    always_comb begin
        w_win = r_rr;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = PW'((int'(r_rr) + k) % NREQ);
            if (req[w_idx]) w_win = w_idx;
        end
`ifdef UART_ARB_PRIO_EN
        if (req[0]) w_win = '0;
`endif
    end

`ifdef UART_ARB_PRIO_EN
    assign w_exempt = (r_g == '0);
`else
    assign w_exempt = 1'b0;
`endif

    assign w_xfer    = (r_state == S_XFER);
    assign w_accept  = w_xfer & req[r_g] & ~tx_full;
    assign w_limit   = (r_cnt == CW'(MAX_BURST - 1)) & ~w_exempt;
    assign w_release = w_xfer & ((w_accept & (req_last[r_g] | w_limit)) | ~req[r_g]);

    assign wr      = w_accept;
    assign w_data  = w_xfer ? req_data[r_g*DBIT +: DBIT] : '0;
    assign req_ack = r_grant & {NREQ{w_accept}};
    assign grant   = r_grant;
    assign busy    = w_xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_g     <= '0;
            r_rr    <= PW'(NREQ - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_grant <= NREQ'(1) << w_win;
                        r_g     <= w_win;
                        r_cnt   <= '0;
                        r_state <= S_XFER;
                    end
                end
                default: begin
                    if (w_release) begin
                        r_grant <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        // A priority owner leaves the rotation point untouched.
                        if (!w_exempt) r_rr <= r_g;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester byte queues plus a packet-level arbitration model.
module tb_uart_tx_arbiter;
    localparam int NREQ      = 4;
    localparam int DBIT      = 8;
    localparam int MAX_BURST = 16;
    localparam int QD        = 256;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DBIT-1:0] req_data = '0;
    logic [NREQ-1:0]      req_last = '0;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      grant;
    logic                 tx_full = 1'b0;
    logic                 wr;
    logic [DBIT-1:0]      w_data;
    logic                 busy;

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
        .req_ack(req_ack), .grant(grant), .tx_full(tx_full), .wr(wr), .w_data(w_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Requester byte queues: bit DBIT flags the last byte of a packet.
    logic [DBIT:0] mem [NREQ][QD];
    int  head [NREQ];
    int  tail [NREQ];
    bit  hold [NREQ];

    // Model state: owner (-1 when idle), rotation pointer, bytes taken this grant.
    int m_own, m_rr, m_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int max_run [NREQ];
    int cur_run;
    int dut_writes;
    int gorder [$];
    logic [DBIT-1:0] wlog [$];
    logic [NREQ-1:0] prev_grant = '0;

    function automatic bit exempt(int o);
`ifdef UART_ARB_PRIO_EN
        return o == 0;
`else
        return o < 0;
`endif
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(int r, int n, int base, bit last_on_end);
        for (int j = 0; j < n; j++) begin
            mem[r][tail[r] % QD] = {last_on_end && (j == n - 1), DBIT'(base + j)};
            tail[r]++;
        end
    endtask

    task automatic model_reset();
        m_own = -1;
        m_rr  = NREQ - 1;
        m_cnt = 0;
    endtask

    task automatic clear_obs();
        gorder.delete();
        wlog.delete();
        dut_writes = 0;
        cur_run = 0;
        for (int i = 0; i < NREQ; i++) max_run[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (head[i] < tail[i]) && !hold[i];
            req_data[i*DBIT +: DBIT] = req[i] ? mem[i][head[i] % QD][DBIT-1:0] : '0;
            req_last[i] = req[i] ? mem[i][head[i] % QD][DBIT] : 1'b0;
        end
    endtask

    // One clock: drive, compare at negedge against the model, advance the model at posedge.
    task automatic step();
        logic [NREQ-1:0] eg, ea;
        logic [DBIT-1:0] ed;
        bit acc;
        int own, win;
        drive();
        @(negedge clk);
        own = m_own;
        acc = (own >= 0) && req[own] && !tx_full;
        eg = '0;
        ea = '0;
        ed = '0;
        if (own >= 0) begin
            eg[own] = 1'b1;
            ed = req_data[own*DBIT +: DBIT];
        end
        if (acc) ea[own] = 1'b1;
        n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL grant: got %b exp %b at %0t", grant, eg, $time); end
        n_checks++; if (busy !== (own >= 0)) begin n_fail++; $display("FAIL busy: got %b exp %b at %0t", busy, own >= 0, $time); end
        n_checks++; if (wr !== acc) begin n_fail++; $display("FAIL wr: got %b exp %b at %0t", wr, acc, $time); end
        n_checks++; if (w_data !== ed) begin n_fail++; $display("FAIL w_data: got %h exp %h at %0t", w_data, ed, $time); end
        n_checks++; if (req_ack !== ea) begin n_fail++; $display("FAIL req_ack: got %b exp %b at %0t", req_ack, ea, $time); end
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < NREQ; i++) if (grant[i]) gorder.push_back(i);
        prev_grant = grant;
        if (wr === 1'b1) begin
            dut_writes++;
            cur_run++;
            wlog.push_back(w_data);
            for (int i = 0; i < NREQ; i++) if (req_ack[i] && cur_run > max_run[i]) max_run[i] = cur_run;
        end
        if (grant == '0) cur_run = 0;
        @(posedge clk);
        if (own < 0) begin
            if (req != '0) begin
                win = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (win < 0 && req[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
                end
`ifdef UART_ARB_PRIO_EN
                if (req[0]) win = 0;
`endif
                m_own = win;
                m_cnt = 0;
            end
        end else if (!req[own] || (acc && (req_last[own] || (m_cnt == MAX_BURST - 1 && !exempt(own))))) begin
            if (!exempt(own)) m_rr = own;
            m_own = -1;
            m_cnt = 0;
        end else if (acc) begin
            m_cnt++;
        end
        if (acc) head[own]++;
        #1;
    endtask

    task automatic drain(int budget, string name);
        int c = 0;
        while (((pending()) || m_own >= 0) && c < budget) begin step(); c++; end
        n_checks++;
        if (c >= budget) begin n_fail++; $display("FAIL %s drain timeout: got %0d cycles, limit %0d", name, c, budget); end
        step();
    endtask

    task automatic wait_own(int r, int cnt, int budget, string name);
        int c = 0;
        while (!(m_own == r && m_cnt == cnt) && c < budget) begin step(); c++; end
        n_checks++;
        if (c >= budget) begin n_fail++; $display("FAIL %s wait timeout: got own %0d cnt %0d, exp %0d/%0d", name, m_own, m_cnt, r, cnt); end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        prev_grant = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL reset grant: got %b exp 0", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b exp 0", busy); end
        n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL reset wr: got %b exp 0", wr); end
        n_checks++; if (req_ack !== '0) begin n_fail++; $display("FAIL reset req_ack: got %b exp 0", req_ack); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [DBIT-1:0] exp_b [3];
        clear_obs();
        push(2, 3, 'hA1, 1'b1);
        drain(100, "single");
        exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3;
        n_checks++; if (dut_writes !== 3) begin n_fail++; $display("FAIL single writes: got %0d exp 3", dut_writes); end
        n_checks++; if (gorder.size() != 1 || gorder[0] != 2) begin n_fail++; $display("FAIL single owner: got %p exp '{2}", gorder); end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (wlog.size() <= j || wlog[j] !== exp_b[j]) begin n_fail++; $display("FAIL single byte%0d: got %p exp %h", j, wlog, exp_b[j]); end
        end
    endtask

    task automatic test_round_robin();
        int exp_o [5];
        apply_reset();
        clear_obs();
        for (int i = 0; i < NREQ; i++) push(i, 1, 'h10 + i, 1'b1);
        push(0, 1, 'h20, 1'b1);
        drain(100, "rr");
        exp_o = '{0, 1, 2, 3, 0};
        n_checks++; if (gorder.size() != 5) begin n_fail++; $display("FAIL rr count: got %0d exp 5", gorder.size()); end
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (gorder.size() <= j || gorder[j] != exp_o[j]) begin n_fail++; $display("FAIL rr order%0d: got %p exp %0d", j, gorder, exp_o[j]); end
        end
    endtask

    task automatic test_backpressure();
        int w0;
        clear_obs();
        push(1, 6, 'h30, 1'b1);
        wait_own(1, 2, 50, "bp");
        tx_full = 1'b1;
        w0 = dut_writes;
        repeat (5) step();
        n_checks++; if (dut_writes != w0) begin n_fail++; $display("FAIL bp held writes: got %0d exp 0", dut_writes - w0); end
        tx_full = 1'b0;
        step();
        n_checks++; if (wlog.size() != 3 || wlog[2] !== 8'h32) begin n_fail++; $display("FAIL bp resume: got %p exp third byte 32", wlog); end
        drain(100, "bp");
        n_checks++; if (wlog.size() != 6) begin n_fail++; $display("FAIL bp count: got %0d exp 6", wlog.size()); end
        for (int j = 0; j < 6 && j < wlog.size(); j++) begin
            n_checks++;
            if (wlog[j] !== DBIT'('h30 + j)) begin n_fail++; $display("FAIL bp byte%0d: got %h exp %h", j, wlog[j], DBIT'('h30 + j)); end
        end
    endtask

    task automatic test_burst();
        apply_reset();
        clear_obs();
        push(1, 20, 'h40, 1'b0);
        push(3, 1, 'h90, 1'b1);
        drain(200, "burst");
        n_checks++; if (max_run[1] != MAX_BURST) begin n_fail++; $display("FAIL burst run: got %0d exp %0d", max_run[1], MAX_BURST); end
        n_checks++; if (dut_writes != 21) begin n_fail++; $display("FAIL burst writes: got %0d exp 21", dut_writes); end
        n_checks++;
        if (gorder.size() != 3 || gorder[0] != 1 || gorder[1] != 3 || gorder[2] != 1) begin
            n_fail++; $display("FAIL burst order: got %p exp '{1,3,1}", gorder);
        end
    endtask

    task automatic test_withdraw();
        clear_obs();
        push(2, 6, 'h50, 1'b1);
        wait_own(2, 2, 50, "wd");
        hold[2] = 1'b1;
        step();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL wd release: got %b exp 0", grant); end
        step();
        hold[2] = 1'b0;
        drain(100, "wd");
        n_checks++; if (wlog.size() != 6 || wlog[5] !== 8'h55) begin n_fail++; $display("FAIL wd bytes: got %p exp 50..55", wlog); end
        n_checks++; if (gorder.size() != 2) begin n_fail++; $display("FAIL wd grants: got %p exp '{2,2}", gorder); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        push(2, 8, 'h60, 1'b1);
        wait_own(2, 3, 50, "rst");
        push(0, 2, 'h70, 1'b1);
        drive();
        reset = 1'b0;
        #1;
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL rst grant: got %b exp 0", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst busy: got %b exp 0", busy); end
        n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL rst wr: got %b exp 0", wr); end
        model_reset();
        prev_grant = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        gorder.delete();
        drain(100, "rst");
        n_checks++; if (gorder.size() < 1 || gorder[0] != 0) begin n_fail++; $display("FAIL rst first grant: got %p exp 0 first", gorder); end
    endtask

`ifdef UART_ARB_PRIO_EN
    task automatic test_prio();
        apply_reset();
        push(1, 1, 'h80, 1'b1);
        drain(50, "prio setup");
        clear_obs();
        push(0, 20, 'hB0, 1'b1);
        push(2, 1, 'hC0, 1'b1);
        drain(200, "prio");
        n_checks++;
        if (gorder.size() != 2 || gorder[0] != 0 || gorder[1] != 2) begin
            n_fail++; $display("FAIL prio order: got %p exp '{0,2}", gorder);
        end
        n_checks++; if (max_run[0] != 20) begin n_fail++; $display("FAIL prio run: got %0d exp 20", max_run[0]); end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        clear_obs();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (tail[i] - head[i] < 40 && $urandom_range(7) == 0)
                    push(i, int'($urandom_range(20, 1)), int'($urandom_range(255)), $urandom_range(3) != 0);
                hold[i] = ($urandom_range(19) == 0);
            end
            tx_full = ($urandom_range(3) == 0);
            step();
        end
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        tx_full = 1'b0;
        drain(2000, "random");
        n_checks++;
        if (max_run[1] > MAX_BURST || max_run[2] > MAX_BURST || max_run[3] > MAX_BURST) begin
            n_fail++; $display("FAIL random burst cap: got %p exp each <= %0d", max_run, MAX_BURST);
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; hold[i] = 1'b0; end
        model_reset();
        clear_obs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_burst();
        test_withdraw();
        test_reset_mid();
`ifdef UART_ARB_PRIO_EN
        test_prio();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit path (TX FIFO write port feeding the uart_tx serializer) between NREQ independent byte-stream requesters. Grants one requester at a time, with round-robin fairness. A grant is held for a whole packet, up to MAX_BURST bytes. Sits between client logic and the TX FIFO's wr/w_data/full interface.

Parameters:
NREQ, 4, number of requesters (2..8)
DBIT, 8, data bits per byte; matches UART DBIT
MAX_BURST, 16, maximum bytes accepted per grant before forced release (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (0 = reset asserted)
req  in  NREQ  per-requester byte valid; held high while the requester has a byte to send
req_data  in  NREQ*DBIT  per-requester byte; requester i occupies bits [i*DBIT +: DBIT]
req_last  in  NREQ  qualifies req_data as the final byte of the requester's packet
req_ack  out  NREQ  one-hot accept strobe; byte of requester i consumed this cycle
grant  out  NREQ  one-hot current owner; all zero when idle
tx_full  in  1  TX FIFO full flag
wr  out  1  TX FIFO write strobe
w_data  out  DBIT  TX FIFO write data
busy  out  1  high while any grant is active (state XFER)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, grant=0, rr_ptr=NREQ-1, burst_cnt=0, busy=0. wr and req_ack are forced to 0 because they decode from state.
- States:
  - IDLE: if req != 0, select the winner and register grant. Go to XFER next cycle. Otherwise stay in IDLE.
  - XFER: the granted index g is the owner. busy=1.
- Round-robin selection: search from index rr_ptr+1 upward, modulo NREQ. The first set req bit wins.
- Arbitration latency: a request seen in IDLE at cycle n gives grant at n+1. The earliest accept is at cycle n+1.
- Accept (combinational, XFER only): accept = req[g] & ~tx_full.
  - wr = accept.
  - w_data = req_data[g*DBIT +: DBIT] whenever in XFER; 0 in IDLE.
  - req_ack = grant & {NREQ{accept}}.
  - The byte is consumed in the same cycle; zero added latency.
- tx_full=1: wr=0, req_ack=0, and the grant is held. No byte is ever written while tx_full=1.
- burst_cnt increments on each accept and clears on release.
- Release conditions (evaluated at the clock edge, checked in XFER):
  - (a) accept & req_last[g]
  - (b) accept & burst_cnt == MAX_BURST-1
  - (c) req[g]==0, i.e. the requester withdrew
- On release: grant=0, rr_ptr=g, burst_cnt=0, state=IDLE. Re-arbitration follows, so there is at least one dead cycle between grants.
- Requests from non-granted requesters are ignored in XFER. Their req_ack stays 0.
- Simultaneous events:
  - A last byte arriving with tx_full=1 is not accepted, so no release happens.
  - Conditions (a) and (b) together give a single release.
  - All req bits set at arbitration: the winner is rr_ptr+1 mod NREQ.
- Reset asserted mid-packet: return to IDLE immediately. Bytes already written stay in the FIFO; the partial packet is not flagged.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and g are $clog2(NREQ) bits, with a minimum of 1.
  - Pointer wrap from NREQ-1 goes to 0.

Optional Feature:
UART_ARB_PRIO_EN
- Defined:
  - Requester 0 is high priority. If req[0]=1 in IDLE it wins regardless of rr_ptr.
  - Its grants are exempt from release condition (b), the MAX_BURST limit.
  - rr_ptr is not updated when requester 0 releases.
  - The other requesters keep round-robin among themselves.
- Undefined: pure round-robin across all NREQ requesters, with MAX_BURST applied to every requester.

Test Plan:
- Single requester: req[2]=1 with 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3), tx_full=0 -> grant=4'b0100 one cycle after req; wr high for 3 consecutive cycles with w_data A1, A2, A3; req_ack[2] on each; grant=0 after the third byte.
- Round-robin: all req=4'b1111 with single-byte packets (req_last=1), starting from reset -> grant order 0, 1, 2, 3, 0, with exactly one IDLE cycle between grants.
- Backpressure: during a granted packet, tx_full=1 for 5 cycles -> wr=0 and req_ack=0 for those 5 cycles; grant held; the byte is written on the first cycle after tx_full falls; no byte lost or duplicated.
- Burst limit: MAX_BURST=16, req[1] streams 20 bytes with no last, req[3] also pending -> exactly 16 writes from requester 1, then requester 3 is granted; requester 1 is regranted later.
- Withdrawal and reset: requester drops req mid-packet -> grant released next edge. Separately, reset=0 asserted mid-packet -> grant=0, busy=0, wr=0 asynchronously; after reset=1 the first grant goes to requester 0.
- UART_ARB_PRIO_EN defined: req[0] and req[2] pending with rr_ptr=1 -> requester 0 wins; a 20-byte requester-0 packet completes without forced release.
